// File: rtl/dr_async_pkg.sv
// rtl/dr_async_pkg.sv - shared types, constants and dual-rail helpers
// Purpose: state enums for the dual-rail FIFO bridge and width-generic
//   dual-rail encode/decode/classify functions.
// Contents: in_state_t, out_state_t, DR_NULL, dr_encode, dr_decode,
//   dr_complete, dr_null, dr_illegal.
package dr_async_pkg;

  // Helpers work on a fixed maximum width; callers zero-extend their
  // vectors and pass the live width, so one function serves every WIDTH
  // up to DR_MAX_W.
  localparam int DR_MAX_W = 64;

  typedef logic [DR_MAX_W-1:0]   dr_word_t;
  typedef logic [2*DR_MAX_W-1:0] dr_rails_t;

  typedef enum logic {IN_WAIT, IN_ACK} in_state_t;
  typedef enum logic {OUT_SPACER, OUT_DATA} out_state_t;

  localparam dr_rails_t DR_NULL = '0;

  // Bit i: true rail at [2i+1], false rail at [2i].
  function automatic dr_rails_t dr_encode(input dr_word_t word, input int width);
    dr_rails_t r;
    r = DR_NULL;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < width) begin
        r[2*i+1] = word[i];
        r[2*i]   = ~word[i];
      end
    end
    return r;
  endfunction

  function automatic dr_word_t dr_decode(input dr_rails_t rails, input int width);
    dr_word_t w;
    w = '0;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < width) w[i] = rails[2*i+1];
    end
    return w;
  endfunction

  function automatic logic dr_complete(input dr_rails_t rails, input int width);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < width) ok = ok & (rails[2*i+1] ^ rails[2*i]);
    end
    return ok;
  endfunction

  function automatic logic dr_null(input dr_rails_t rails, input int width);
    logic z;
    z = 1'b1;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < width) z = z & ~rails[2*i+1] & ~rails[2*i];
    end
    return z;
  endfunction

  function automatic logic dr_illegal(input dr_rails_t rails, input int width);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < width) bad = bad | (rails[2*i+1] & rails[2*i]);
    end
    return bad;
  endfunction

endpackage

// File: rtl/sync_nff_vec.sv
// rtl/sync_nff_vec.sv - N-bit, STAGES-deep flop synchroniser
// Purpose: bring asynchronous signals into the clk domain.
// Ports: clk, rst_n (async active-low, clears to 0), d[N-1:0] async in,
//   q[N-1:0] synchronised out.
module sync_nff_vec #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) chain[s] <= '0;
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dr_sync_fifo_buffer.sv
// rtl/dr_sync_fifo_buffer.sv - dual-rail four-phase channel to clocked FIFO bridge
// Purpose: accept WIDTH-bit four-phase dual-rail words, queue DEPTH of them,
//   re-emit them on a four-phase dual-rail output channel.
// Ports: clk, rst_n (async active-low); data_in/ack_ant upstream channel;
//   data_out/ack_next downstream channel; level = stored entries;
//   err = sticky illegal-codeword flag.
module dr_sync_fifo_buffer
  import dr_async_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2*WIDTH-1:0]         data_in,
  output logic                       ack_ant,
  output logic [2*WIDTH-1:0]         data_out,
  input  logic                       ack_next,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err
);

  localparam int RW = 2 * WIDTH;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [RW-1:0]    rails_s;
  logic             ack_s;
  logic             complete, is_null, illegal, full;
  logic             push, pop;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  in_state_t        in_state, in_state_nxt;
  out_state_t       out_state, out_state_nxt;
  logic             ack_ant_nxt, err_nxt;
  logic [RW-1:0]    data_out_nxt;
  logic [LW-1:0]    level_nxt;

  sync_nff_vec #(.N(RW), .STAGES(SYNC_STAGES)) u_sync_rails (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (rails_s)
  );

  sync_nff_vec #(.N(1), .STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_next),
    .q     (ack_s)
  );

  assign complete = dr_complete(dr_rails_t'(rails_s), WIDTH);
  assign is_null  = dr_null(dr_rails_t'(rails_s), WIDTH);
  assign illegal  = dr_illegal(dr_rails_t'(rails_s), WIDTH);
  // Registered level only: a pop in the same cycle does not make room.
  assign full     = (level == LW'(DEPTH));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Input channel FSM
  always_comb begin
    in_state_nxt = in_state;
    ack_ant_nxt  = ack_ant;
    err_nxt      = err | illegal;
    push         = 1'b0;
    case (in_state)
      IN_WAIT: begin
        if (complete && !full && !err) begin
          push         = 1'b1;
          ack_ant_nxt  = 1'b1;
          in_state_nxt = IN_ACK;
        end
      end
      IN_ACK: begin
        if (is_null) begin
          ack_ant_nxt  = 1'b0;
          in_state_nxt = IN_WAIT;
        end
      end
      default: in_state_nxt = IN_WAIT;
    endcase
  end

  // Output channel FSM; data_out moves between NULL and a full codeword
  // in one registered step so the receiver never sees a partial word.
  always_comb begin
    out_state_nxt = out_state;
    data_out_nxt  = data_out;
    pop           = 1'b0;
    case (out_state)
      OUT_SPACER: begin
        if (!ack_s && (level != '0)) begin
          data_out_nxt  = RW'(dr_encode(dr_word_t'(mem[rd_ptr]), WIDTH));
          out_state_nxt = OUT_DATA;
        end
      end
      OUT_DATA: begin
        if (ack_s) begin
          pop           = 1'b1;
          data_out_nxt  = RW'(DR_NULL);
          out_state_nxt = OUT_SPACER;
        end
      end
      default: out_state_nxt = OUT_SPACER;
    endcase
  end

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= IN_WAIT;
      out_state <= OUT_SPACER;
      ack_ant   <= 1'b0;
      err       <= 1'b0;
      data_out  <= '0;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
      ack_ant   <= ack_ant_nxt;
      err       <= err_nxt;
      data_out  <= data_out_nxt;
      level     <= level_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage needs no reset: entries are only read once counted in level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= WIDTH'(dr_decode(dr_rails_t'(rails_s), WIDTH));
  end

endmodule

// File: tb/tb_dr_sync_fifo_buffer.sv
// tb/tb_dr_sync_fifo_buffer.sv - directed bench for dr_sync_fifo_buffer
module tb_dr_sync_fifo_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       ack_ant;
  logic [7:0] data_out;
  logic       ack_next;
  logic [2:0] level;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dr_sync_fifo_buffer #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .ack_ant  (ack_ant),
    .data_out (data_out),
    .ack_next (ack_next),
    .level    (level),
    .err      (err)
  );

  function automatic logic [7:0] enc(input logic [3:0] w);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      0:       return {31'd0, ack_ant};
      1:       return {24'd0, data_out};
      2:       return {29'd0, level};
      default: return {31'd0, err};
    endcase
  endfunction

  // sel: 0 ack_ant, 1 data_out, 2 level, 3 err; waits at most budget cycles
  task automatic wait_for(input string tag, input int sel, input logic [31:0] exp, input int budget);
    int n = 0;
    logic [31:0] got;
    got = sample(sel);
    while (got !== exp && n < budget) begin
      @(negedge clk);
      n++;
      got = sample(sel);
    end
    check(tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    data_in  = 8'h00;
    ack_next = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input string tag, input logic [3:0] w);
    data_in = enc(w);
    wait_for({tag, "_ack_hi"}, 0, 1, 3);
    data_in = 8'h00;
    wait_for({tag, "_ack_lo"}, 0, 0, 4);
  endtask

  initial begin
    // reset with all rails high on the input
    rst_n    = 1'b0;
    data_in  = 8'hFF;
    ack_next = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout", {24'd0, data_out}, 32'h00);
    check("rst_ack", {31'd0, ack_ant}, 0);
    check("rst_level", {29'd0, level}, 0);
    check("rst_err", {31'd0, err}, 0);
    rst_n = 1'b1;
    wait_for("rel_err", 3, 1, 3);
    check("rel_ack", {31'd0, ack_ant}, 0);

    // single word 1010
    do_reset();
    data_in = 8'b10011001;
    wait_for("w1_ack", 0, 1, 3);
    check("w1_level", {29'd0, level}, 1);
    wait_for("w1_dout", 1, 32'h99, 3);
    ack_next = 1'b1;
    wait_for("w1_pop", 1, 0, 4);
    check("w1_level0", {29'd0, level}, 0);
    data_in = 8'h00;
    wait_for("w1_ack_lo", 0, 0, 4);
    ack_next = 1'b0;
    repeat (3) @(negedge clk);

    // partial word: bit3 rails 00
    data_in = 8'b00100110;
    repeat (20) @(negedge clk);
    check("part_ack", {31'd0, ack_ant}, 0);
    check("part_level", {29'd0, level}, 0);
    data_in = 8'b01100110;
    wait_for("part_done_ack", 0, 1, 3);
    wait_for("part_dout", 1, {24'd0, enc(4'b0101)}, 3);
    ack_next = 1'b1;
    wait_for("part_pop", 1, 0, 4);
    data_in = 8'h00;
    wait_for("part_ack_lo", 0, 0, 4);
    ack_next = 1'b0;
    repeat (3) @(negedge clk);

    // fill to DEPTH, fifth word must wait
    for (int w = 1; w <= 4; w++) send_word($sformatf("fill%0d", w), 4'(w));
    check("full_level", {29'd0, level}, 4);
    check("full_dout", {24'd0, data_out}, {24'd0, enc(4'd1)});
    data_in = enc(4'd5);
    repeat (10) @(negedge clk);
    check("w5_noack", {31'd0, ack_ant}, 0);
    check("w5_level", {29'd0, level}, 4);
    check("w5_dout_hold", {24'd0, data_out}, {24'd0, enc(4'd1)});
    ack_next = 1'b1;
    wait_for("w1_popped", 1, 0, 4);
    ack_next = 1'b0;
    wait_for("w5_ack", 0, 1, 4);
    wait_for("w2_dout", 1, {24'd0, enc(4'd2)}, 4);
    check("w5_level4", {29'd0, level}, 4);
    data_in = 8'h00;
    wait_for("w5_ack_lo", 0, 0, 4);
    ack_next = 1'b1;
    wait_for("w2_pop", 1, 0, 4);
    ack_next = 1'b0;
    for (int w = 3; w <= 5; w++) begin
      wait_for($sformatf("drain%0d", w), 1, {24'd0, enc(4'(w))}, 4);
      ack_next = 1'b1;
      wait_for($sformatf("drain%0d_pop", w), 1, 0, 4);
      ack_next = 1'b0;
    end
    check("drain_level", {29'd0, level}, 0);
    repeat (3) @(negedge clk);

    // illegal codeword is fatal
    data_in = 8'b11010101;
    wait_for("ill_err", 3, 1, 3);
    data_in = 8'h00;
    repeat (5) @(negedge clk);
    check("ill_err_sticky", {31'd0, err}, 1);
    data_in = enc(4'd3);
    repeat (10) @(negedge clk);
    check("ill_noack", {31'd0, ack_ant}, 0);
    check("ill_level", {29'd0, level}, 0);
    check("ill_err_held", {31'd0, err}, 1);

    // asynchronous reset mid-handshake
    do_reset();
    send_word("mid1", 4'd6);
    data_in = enc(4'd9);
    wait_for("mid2_ack", 0, 1, 3);
    wait_for("mid_level2", 2, 2, 2);
    check("mid_dout", {24'd0, data_out}, {24'd0, enc(4'd6)});
    #2 rst_n = 1'b0;
    #1;
    check("arst_ack", {31'd0, ack_ant}, 0);
    check("arst_dout", {24'd0, data_out}, 0);
    check("arst_level", {29'd0, level}, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
